// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: datapath widths, ALU opcodes,
// owner encodings for the response slot and the slot state type.
package alu_share_arbiter_pkg;

    localparam int XLEN        = 32;
    localparam int ALUOPS_SIZE = 4;
    localparam int SHAMT_W     = $clog2(XLEN);

    // ALU opcodes; encodings 10..15 are undefined and yield a zero result
    localparam logic [ALUOPS_SIZE-1:0] ALU_OP_ADD  = 4'd0;
    localparam logic [ALUOPS_SIZE-1:0] ALU_OP_SUB  = 4'd1;
    localparam logic [ALUOPS_SIZE-1:0] ALU_OP_AND  = 4'd2;
    localparam logic [ALUOPS_SIZE-1:0] ALU_OP_OR   = 4'd3;
    localparam logic [ALUOPS_SIZE-1:0] ALU_OP_XOR  = 4'd4;
    localparam logic [ALUOPS_SIZE-1:0] ALU_OP_SLL  = 4'd5;
    localparam logic [ALUOPS_SIZE-1:0] ALU_OP_SRL  = 4'd6;
    localparam logic [ALUOPS_SIZE-1:0] ALU_OP_SRA  = 4'd7;
    localparam logic [ALUOPS_SIZE-1:0] ALU_OP_SLT  = 4'd8;
    localparam logic [ALUOPS_SIZE-1:0] ALU_OP_SLTU = 4'd9;

    // Owner encodings for the response slot and the round-robin pointer
    localparam logic ARB_PORT0 = 1'b0;
    localparam logic ARB_PORT1 = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU clients and the arbiter.
// master = requester side (integer pipe + FPU helper), slave = arbiter.
interface alu_share_arbiter_if;
    import alu_share_arbiter_pkg::*;

    logic                   req0_valid;
    logic                   req0_ready;
    logic [XLEN-1:0]        req0_a;
    logic [XLEN-1:0]        req0_b;
    logic [ALUOPS_SIZE-1:0] req0_op;

    logic                   req1_valid;
    logic                   req1_ready;
    logic [XLEN-1:0]        req1_a;
    logic [XLEN-1:0]        req1_b;
    logic [ALUOPS_SIZE-1:0] req1_op;

    logic                   rsp0_valid;
    logic                   rsp0_ready;
    logic                   rsp1_valid;
    logic                   rsp1_ready;
    logic [XLEN-1:0]        rsp_result;
    logic                   busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, busy
    );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational integer ALU shared by both arbiter ports.
// Wrap-around arithmetic, shifts use the low bits of operand B,
// undefined opcodes return zero.
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
(
    input  logic [XLEN-1:0]        i_a,
    input  logic [XLEN-1:0]        i_b,
    input  logic [ALUOPS_SIZE-1:0] i_op,
    output logic [XLEN-1:0]        o_result
);

    logic signed [XLEN-1:0] w_a_s;
    logic signed [XLEN-1:0] w_b_s;
    logic [SHAMT_W-1:0]     w_shamt;

    assign w_a_s   = i_a;
    assign w_b_s   = i_b;
    assign w_shamt = i_b[SHAMT_W-1:0];

    // Decode the opcode and compute the result
    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_OP_ADD:  o_result = i_a + i_b;
            ALU_OP_SUB:  o_result = i_a - i_b;
            ALU_OP_AND:  o_result = i_a & i_b;
            ALU_OP_OR:   o_result = i_a | i_b;
            ALU_OP_XOR:  o_result = i_a ^ i_b;
            ALU_OP_SLL:  o_result = i_a << w_shamt;
            ALU_OP_SRL:  o_result = i_a >> w_shamt;
            ALU_OP_SRA:  o_result = $unsigned(w_a_s >>> w_shamt);
            ALU_OP_SLT:  o_result = {{(XLEN-1){1'b0}}, (w_a_s < w_b_s)};
            ALU_OP_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            default:     o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one integer ALU between the integer pipe
// (port 0) and the FPU integer-helper path (port 1). The ALU output is
// captured in a single-entry response slot tagged with its owner; a slot
// being drained can be refilled in the same cycle for 1 op/cycle throughput.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus
);

    slot_state_e            r_state;
    logic                   r_owner;
    logic                   r_last_grant;
    logic                   r_rsp0_valid;
    logic                   r_rsp1_valid;
    logic [XLEN-1:0]        r_rsp_result;

    logic                   w_drain;
    logic                   w_can_accept;
    logic                   w_grant0;
    logic                   w_grant1;
    logic                   w_accept;
    logic                   w_sel;
    logic [XLEN-1:0]        w_alu_a;
    logic [XLEN-1:0]        w_alu_b;
    logic [ALUOPS_SIZE-1:0] w_alu_op;
    logic [XLEN-1:0]        w_alu_result;

    // Decide whether the slot frees up this cycle and who gets the ALU;
    // grants are suppressed while reset is held so nothing is accepted
    always_comb begin
        w_drain      = (r_state == ST_FULL) &&
                       ((r_owner == ARB_PORT1) ? bus.rsp1_ready : bus.rsp0_ready);
        w_can_accept = rst_n && ((r_state == ST_EMPTY) || w_drain);
        w_grant0     = w_can_accept && bus.req0_valid &&
                       (!bus.req1_valid || (r_last_grant == ARB_PORT1));
        w_grant1     = w_can_accept && bus.req1_valid &&
                       (!bus.req0_valid || (r_last_grant == ARB_PORT0));
        w_accept     = w_grant0 || w_grant1;
        w_sel        = w_grant1 ? ARB_PORT1 : ARB_PORT0;
        w_alu_a      = w_grant1 ? bus.req1_a  : bus.req0_a;
        w_alu_b      = w_grant1 ? bus.req1_b  : bus.req0_b;
        w_alu_op     = w_grant1 ? bus.req1_op : bus.req0_op;
    end

    alu_share_arbiter_alu u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_op     (w_alu_op),
        .o_result (w_alu_result)
    );

    // Slot FSM: capture on accept (possibly while draining), empty on drain alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_owner      <= ARB_PORT0;
            r_last_grant <= ARB_PORT1;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_result <= '0;
        end else if (w_accept) begin
            r_state      <= ST_FULL;
            r_owner      <= w_sel;
            r_last_grant <= w_sel;
            r_rsp0_valid <= (w_sel == ARB_PORT0);
            r_rsp1_valid <= (w_sel == ARB_PORT1);
            r_rsp_result <= w_alu_result;
        end else if (w_drain) begin
            r_state      <= ST_EMPTY;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.busy       = (r_state == ST_FULL) || bus.req0_valid || bus.req1_valid;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_share_arbiter_if bus ();

    alu_share_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic            owner;
        logic [XLEN-1:0] res;
    } slot_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    slot_t       slot_q[$];
    logic        m_last;
    logic        obs_r0, obs_r1, obs_v0, obs_v1;
    logic [XLEN-1:0] obs_res;

    // Reference ALU from plain arithmetic on unsigned values
    function automatic logic [XLEN-1:0] alu_ref(input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b,
                                                input logic [ALUOPS_SIZE-1:0] op);
        logic [2*XLEN-1:0] ext;
        int sh;
        sh = int'(b % XLEN);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: begin
                ext = {{XLEN{a[XLEN-1]}}, a};
                ext = ext >> sh;
                return ext[XLEN-1:0];
            end
            4'd8: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        slot_q.delete();
        m_last = 1'b1;
    endtask

    // One clock: check outputs at negedge against the model, advance model at posedge
    task automatic cycle();
        logic full, own, drain, can, g0, g1;
        @(negedge clk);
        full  = (slot_q.size() != 0);
        own   = full ? slot_q[0].owner : 1'b0;
        drain = full && (own ? bus.rsp1_ready : bus.rsp0_ready);
        can   = !full || drain;
        g0    = can && bus.req0_valid && (!bus.req1_valid || m_last);
        g1    = can && bus.req1_valid && (!bus.req0_valid || !m_last);
        obs_r0  = bus.req0_ready;
        obs_r1  = bus.req1_ready;
        obs_v0  = bus.rsp0_valid;
        obs_v1  = bus.rsp1_valid;
        obs_res = bus.rsp_result;
        chk1("req0_ready", obs_r0, g0);
        chk1("req1_ready", obs_r1, g1);
        chk1("rsp0_valid", obs_v0, full && !own);
        chk1("rsp1_valid", obs_v1, full && own);
        chk1("busy", bus.busy, full || bus.req0_valid || bus.req1_valid);
        if (full) chk("rsp_result", obs_res, slot_q[0].res);
        @(posedge clk);
        if (drain) void'(slot_q.pop_front());
        if (g0) begin
            slot_q.push_back('{owner: 1'b0, res: alu_ref(bus.req0_a, bus.req0_b, bus.req0_op)});
            m_last = 1'b0;
        end
        if (g1) begin
            slot_q.push_back('{owner: 1'b1, res: alu_ref(bus.req1_a, bus.req1_b, bus.req1_op)});
            m_last = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive0(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [ALUOPS_SIZE-1:0] op);
        bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    endtask

    task automatic drive1(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [ALUOPS_SIZE-1:0] op);
        bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XLEN-1:0]        bnd_a  [5];
        logic [XLEN-1:0]        bnd_b  [5];
        logic [ALUOPS_SIZE-1:0] bnd_op [5];
        logic [XLEN-1:0]        bnd_exp[5];

        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;

        // Reset state: nothing held, nothing accepted even with a valid request
        drive0(32'd1, 32'd2, ALU_OP_ADD);
        @(negedge clk);
        chk1("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
        chk1("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
        chk("rst_result", bus.rsp_result, 32'd0);
        chk1("rst_req0_ready", bus.req0_ready, 1'b0);
        chk1("rst_busy", bus.busy, 1'b1);
        bus.req0_valid = 1'b0;
        do_reset();

        // Test 1: single ADD on port 0
        drive0(32'd5, 32'd7, ALU_OP_ADD);
        cycle();
        chk1("t1_req0_ready", obs_r0, 1'b1);
        bus.req0_valid = 1'b0;
        cycle();
        chk1("t1_rsp0_valid", obs_v0, 1'b1);
        chk1("t1_rsp1_valid", obs_v1, 1'b0);
        chk("t1_result", obs_res, 32'd12);
        cycle();

        // Test 2: simultaneous requests after reset, port 0 wins first
        do_reset();
        drive0(32'd10, 32'd3, ALU_OP_SUB);
        drive1(32'h0000_00F0, 32'h0000_000F, ALU_OP_XOR);
        cycle();
        chk1("t2_first_r0", obs_r0, 1'b1);
        chk1("t2_first_r1", obs_r1, 1'b0);
        bus.req0_valid = 1'b0;
        cycle();
        chk1("t2_second_r1", obs_r1, 1'b1);
        chk1("t2_v0", obs_v0, 1'b1);
        chk("t2_res0", obs_res, 32'd7);
        bus.req1_valid = 1'b0;
        cycle();
        chk1("t2_v1", obs_v1, 1'b1);
        chk1("t2_v0_off", obs_v0, 1'b0);
        chk("t2_res1", obs_res, 32'h0000_00FF);

        // Test 3: backpressure on a port-1 result blocks port 0
        bus.rsp1_ready = 1'b0;
        drive1(32'd1, 32'd2, ALU_OP_ADD);
        cycle();
        chk1("t3_grant1", obs_r1, 1'b1);
        bus.req1_valid = 1'b0;
        drive0(32'h0000_FF00, 32'h0000_0FF0, ALU_OP_AND);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk1("t3_bp_r0", obs_r0, 1'b0);
            chk("t3_bp_res", obs_res, 32'd3);
        end
        bus.rsp1_ready = 1'b1;
        cycle();
        chk1("t3_refill_r0", obs_r0, 1'b1);
        chk1("t3_refill_v1", obs_v1, 1'b1);
        bus.req0_valid = 1'b0;
        cycle();
        chk1("t3_v0", obs_v0, 1'b1);
        chk("t3_res0", obs_res, 32'h0000_0F00);
        cycle();

        // Test 4: sustained contention alternates grants starting at port 0
        do_reset();
        drive0($urandom(), $urandom(), 4'($urandom_range(0, 9)));
        drive1($urandom(), $urandom(), 4'($urandom_range(0, 9)));
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk1("t4_grant_seq", obs_r1, (i % 2) == 1);
            chk1("t4_one_grant", obs_r0 ^ obs_r1, 1'b1);
            if (obs_r0) drive0($urandom(), $urandom(), 4'($urandom_range(0, 9)));
            if (obs_r1) drive1($urandom(), $urandom(), 4'($urandom_range(0, 9)));
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        cycle();
        cycle();

        // Test 5: boundary operands
        bnd_a[0] = 32'hFFFF_FFFF; bnd_b[0] = 32'd1;          bnd_op[0] = ALU_OP_ADD;  bnd_exp[0] = 32'd0;
        bnd_a[1] = 32'h8000_0000; bnd_b[1] = 32'd31;         bnd_op[1] = ALU_OP_SRA;  bnd_exp[1] = 32'hFFFF_FFFF;
        bnd_a[2] = 32'd1;         bnd_b[2] = 32'hFFFF_FFFF;  bnd_op[2] = ALU_OP_SLTU; bnd_exp[2] = 32'd1;
        bnd_a[3] = 32'd123;       bnd_b[3] = 32'd456;        bnd_op[3] = 4'd15;       bnd_exp[3] = 32'd0;
        bnd_a[4] = 32'hFFFF_FFFF; bnd_b[4] = 32'd1;          bnd_op[4] = ALU_OP_SLT;  bnd_exp[4] = 32'd1;
        for (int i = 0; i < 5; i++) begin
            drive0(bnd_a[i], bnd_b[i], bnd_op[i]);
            cycle();
            bus.req0_valid = 1'b0;
            cycle();
            chk("t5_boundary", obs_res, bnd_exp[i]);
        end

        // Test 6: asynchronous reset while the slot is full
        bus.rsp0_ready = 1'b0;
        drive0(32'd1, 32'd1, ALU_OP_ADD);
        cycle();
        bus.req0_valid = 1'b0;
        #2;
        chk1("t6_full_before", bus.rsp0_valid, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk1("t6_async_v0", bus.rsp0_valid, 1'b0);
        chk1("t6_async_v1", bus.rsp1_valid, 1'b0);
        chk("t6_async_res", bus.rsp_result, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.rsp0_ready = 1'b1;
        drive0(32'd2, 32'd3, ALU_OP_OR);
        drive1(32'd4, 32'd5, ALU_OP_AND);
        cycle();
        chk1("t6_tie_r0", obs_r0, 1'b1);
        chk1("t6_tie_r1", obs_r1, 1'b0);
        bus.req0_valid = 1'b0;
        cycle();
        bus.req1_valid = 1'b0;
        cycle();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            if (!bus.req0_valid && $urandom_range(0, 2) != 0)
                drive0($urandom(), (($urandom_range(0, 3) == 0) ? 32'd31 : $urandom()),
                       4'($urandom_range(0, 15)));
            if (!bus.req1_valid && $urandom_range(0, 2) != 0)
                drive1($urandom(), (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom()),
                       4'($urandom_range(0, 15)));
            bus.rsp0_ready = ($urandom_range(0, 3) != 0);
            bus.rsp1_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (obs_r0) bus.req0_valid = 1'b0;
            if (obs_r1) bus.req1_valid = 1'b0;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one integer ALU between two requesters: port 0 is the integer pipe, port 1 is the FPU integer-helper path (fmv/fcvt/compare post-processing).
- Each port uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. The ALU output is registered in a single-entry response slot tagged with its owner.
- Sits between the execute stage / FPU control and the single shared alu instance.

Parameters:
- XLEN, 32, datapath width (from archerdefs)
- ALUOPS_SIZE, 4, ALU opcode width (from archerdefs)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle
- req0_a  in  XLEN  port 0 operand A
- req0_b  in  XLEN  port 0 operand B
- req0_op  in  ALUOPS_SIZE  port 0 ALU opcode
- req1_valid  in  1  port 1 request valid
- req1_ready  out  1  port 1 request accepted this cycle
- req1_a  in  XLEN  port 1 operand A
- req1_b  in  XLEN  port 1 operand B
- req1_op  in  ALUOPS_SIZE  port 1 ALU opcode
- rsp0_valid  out  1  result for port 0 held in slot
- rsp0_ready  in  1  port 0 consumes result
- rsp1_valid  out  1  result for port 1 held in slot
- rsp1_ready  in  1  port 1 consumes result
- rsp_result  out  XLEN  registered ALU result, shared by both response channels
- busy  out  1  slot full or any request pending

Behaviour:
- Reset (async, rst_n=0):
  - slot state EMPTY; rsp0_valid=0, rsp1_valid=0, rsp_result=0.
  - last_grant=1, so port 0 wins the first tie.
  - A held result is discarded. No request is accepted while in reset.
- FSM states:
  - EMPTY: slot holds nothing.
  - FULL: slot holds a result plus owner bit. rsp{owner}_valid=1; the other rsp valid is 0.
- drain = FULL && rsp{owner}_ready.
- can_accept = EMPTY || drain. This gives pass-through refill, so throughput is 1 op/cycle when the consumer keeps up.
- Grant, combinational, only when can_accept:
  - Only one valid requester: grant it.
  - Both valid: grant !last_grant.
  - reqN_ready = grantN. At most one ready is high per cycle.
  - Ready may depend on valid. A requester must hold valid, a, b and op stable until ready.
- On accept (reqN_valid && reqN_ready), at the clock edge:
  - rsp_result <= alu(reqN_a, reqN_b, reqN_op).
  - owner <= N; last_grant <= N; state <= FULL.
- Latency: exactly 1 cycle from accept to rspN_valid.
- Drain with no accept: state <= EMPTY; rsp_result holds its old value (don't-care).
- FULL and not drained: both req ready=0, slot unchanged (backpressure). last_grant does not change without an accept.
- Fairness: with both requesters continuously valid and responses always drained, grants alternate 0,1,0,1. Worst-case wait is 1 grant.
- Opcodes not defined in archerdefs produce result 0, per alu default. No error flag.
- busy = FULL || req0_valid || req1_valid.
- Arithmetic: wrap-around modulo 2^XLEN; no overflow signalling.

Decomposition:
- Shared package (archerdefs): XLEN, ALUOPS_SIZE, ALU_OP_* opcodes. Add ARB_PORT0=1'b0 and ARB_PORT1=1'b1 owner encodings there.
- One sub-module: the existing alu, instantiated once. Its inputs are muxed by the grant; its output feeds the slot register.
- Grant logic and FSM stay inline.

Test Plan:
1. Reset then single op: req0 ADD a=5, b=7 at cycle 0, rsp0_ready=1 → req0_ready=1 at cycle 0; rsp0_valid=1 with rsp_result=12 at cycle 1; rsp1_valid stays 0.
2. Simultaneous requests after reset: req0 SUB 10-3 and req1 XOR 0xF0^0x0F, both valid, rsp always ready → port 0 granted first (result 7), port 1 next cycle (0xFF). Back-to-back, no bubble.
3. Backpressure: slot FULL for port 1 with rsp1_ready=0 for 4 cycles while req0 is valid → req0_ready=0 for those 4 cycles, rsp_result stable. The cycle rsp1_ready=1, req0_ready=1 (pass-through refill).
4. Sustained contention: both valid for 8 cycles → grant sequence 0,1,0,1,0,1,0,1 and each result routed only to its owner.
5. Boundaries: ADD 0xFFFFFFFF+1 → 0; SRA 0x80000000 by 31 → 0xFFFFFFFF; SLTU 1<0xFFFFFFFF → 1; undefined opcode → 0.
6. Reset mid-operation: assert rst_n=0 while FULL → rsp*_valid=0 immediately (async). After release, first tie goes to port 0.
